// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port (WE3/A3/WD3)
// between NREQ writeback requesters; the winning write is registered for one cycle.
module rf_write_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     hold,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     WE3,
    output logic [AW-1:0]            A3,
    output logic [DW-1:0]            WD3,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic [7:0]               x0_drops
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;
    logic          grant;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    logic [AW-1:0] addr_arr [NREQ];
    logic [DW-1:0] data_arr [NREQ];

    // (base + k) mod NREQ, valid for any NREQ, not only powers of two.
    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[IW-1:0];
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
    always_comb begin : grant_search
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && req_valid[rr_index(rr_ptr, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_index(rr_ptr, k);
            end
        end
    end

    assign grant    = RST && !hold && gnt_any;
    assign sel_addr = addr_arr[gnt_idx];
    assign sel_data = data_arr[gnt_idx];

    always_comb begin : ready_decode
        req_ready = '0;
        if (grant) req_ready[gnt_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rr_ptr   <= '0;
            WE3      <= 1'b0;
            A3       <= '0;
            WD3      <= '0;
            grant_id <= '0;
            x0_drops <= '0;
        end else begin
            // Writes to x0 are accepted and counted but never reach the register file.
            WE3 <= grant && (sel_addr != '0);
            if (grant) begin
                rr_ptr   <= rr_index(gnt_idx, 1);
                A3       <= sel_addr;
                WD3      <= sel_data;
                grant_id <= gnt_idx;
                if (sel_addr == '0 && x0_drops != 8'hFF) x0_drops <= x0_drops + 8'd1;
            end
        end
    end

    a_ready_onehot: assert property (@(posedge CLK) disable iff (!RST) $onehot0(req_ready));
    a_ready_valid:  assert property (@(posedge CLK) disable iff (!RST) (req_ready & ~req_valid) == '0);

endmodule
